otp_access_arbiter: RTL and testbench

//  Shares the single OTP sequencer (otp_main) among three requesters: boot autoload (0),

---
 rtl/otp_access_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_otp_access_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_access_arbiter.sv
// -----------------------------------------------------------------------------
// otp_access_arbiter
//
// Shares the single OTP sequencer among three requesters:
//   0 = boot autoload, 1 = register-file / I2C host, 2 = test-mode engine.
// One owner is granted at a time. The arbiter issues a start pulse plus the op
// type, waits for the sequencer's done, aborts on timeout, and then holds a
// recovery gap (VDDQ discharge) before the next arbitration.
//
// Ports
//   sys_clk          in   1  system clock, rising edge
//   rst              in   1  synchronous reset, active-high
//   i_i2c_busy       in   1  1 = hold off new grants (an in-flight op continues)
//   i_run_test_mode  in   1  0 = requester 2 masked
//   i_prog_lock      in   1  1 = program requests rejected
//   i_req            in   3  per-requester level request
//   i_op             in   3  per-requester op, 1=program 0=read (bit0 ignored)
//   o_gnt            out  3  one-hot owner, held from START through WAIT
//   o_done           out  3  1-cycle completion pulse to the owner
//   o_err            out  3  1-cycle pulse on reject or timeout
//   o_otp_start      out  1  1-cycle start pulse to the sequencer
//   o_otp_prog       out  1  op of current owner, valid while o_gnt != 0
//   i_otp_done       in   1  1-cycle completion pulse from the sequencer
//   o_otp_abort      out  1  1-cycle abort pulse on timeout
//   o_busy           out  1  1 whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module otp_access_arbiter #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 4,
    parameter int CNT_W       = 13
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       i_i2c_busy,
    input  logic       i_run_test_mode,
    input  logic       i_prog_lock,
    input  logic [2:0] i_req,
    input  logic [2:0] i_op,
    output logic [2:0] o_gnt,
    output logic [2:0] o_done,
    output logic [2:0] o_err,
    output logic       o_otp_start,
    output logic       o_otp_prog,
    input  logic       i_otp_done,
    output logic       o_otp_abort,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    // 0 = requester 1 wins a 1-vs-2 tie, 1 = requester 2 wins
    logic             rr_ptr, rr_ptr_nxt;

    logic [2:0] eligible;
    logic [2:0] winner;
    logic       win_prog;

    logic [2:0] gnt_nxt, done_nxt, err_nxt;
    logic       start_nxt, prog_nxt, abort_nxt, busy_nxt;

    // Winner selection: autoload has absolute priority, 1 and 2 share by
    // round-robin. Autoload never programs, so its op bit is masked off.
    always_comb begin
        eligible = i_req & {i_run_test_mode, 1'b1, 1'b1};
        winner   = 3'b000;
        if (eligible[0]) begin
            winner = 3'b001;
        end else if (eligible[1] && eligible[2]) begin
            winner = rr_ptr ? 3'b100 : 3'b010;
        end else if (eligible[1]) begin
            winner = 3'b010;
        end else if (eligible[2]) begin
            winner = 3'b100;
        end
        win_prog = |(winner & i_op & 3'b110);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rr_ptr_nxt = rr_ptr;
        gnt_nxt    = o_gnt;
        prog_nxt   = o_otp_prog;
        done_nxt   = 3'b000;
        err_nxt    = 3'b000;
        start_nxt  = 1'b0;
        abort_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (!i_i2c_busy && (winner != 3'b000)) begin
                    if (win_prog && i_prog_lock) begin
                        // Rejected program: no grant, but still observe the gap
                        err_nxt   = winner;
                        state_nxt = GAP;
                        cnt_nxt   = '0;
                    end else begin
                        gnt_nxt   = winner;
                        prog_nxt  = win_prog;
                        start_nxt = 1'b1;
                        state_nxt = START;
                        if (winner[1]) rr_ptr_nxt = 1'b1;
                        if (winner[2]) rr_ptr_nxt = 1'b0;
                    end
                end
            end
            START: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
            WAIT: begin
                // Done has priority over a simultaneous timeout
                if (i_otp_done) begin
                    done_nxt  = o_gnt;
                    gnt_nxt   = 3'b000;
                    prog_nxt  = 1'b0;
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    abort_nxt = 1'b1;
                    err_nxt   = o_gnt;
                    gnt_nxt   = 3'b000;
                    prog_nxt  = 1'b0;
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= 1'b0;
            o_gnt       <= 3'b000;
            o_done      <= 3'b000;
            o_err       <= 3'b000;
            o_otp_start <= 1'b0;
            o_otp_prog  <= 1'b0;
            o_otp_abort <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rr_ptr      <= rr_ptr_nxt;
            o_gnt       <= gnt_nxt;
            o_done      <= done_nxt;
            o_err       <= err_nxt;
            o_otp_start <= start_nxt;
            o_otp_prog  <= prog_nxt;
            o_otp_abort <= abort_nxt;
            o_busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_otp_access_arbiter.sv
`timescale 1ns/1ps
module tb_otp_access_arbiter;

    localparam int TO  = 24;
    localparam int GAP = 4;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       i_i2c_busy;
    logic       i_run_test_mode;
    logic       i_prog_lock;
    logic [2:0] i_req;
    logic [2:0] i_op;
    logic [2:0] o_gnt;
    logic [2:0] o_done;
    logic [2:0] o_err;
    logic       o_otp_start;
    logic       o_otp_prog;
    logic       i_otp_done;
    logic       o_otp_abort;
    logic       o_busy;

    always #5 sys_clk = ~sys_clk;

    otp_access_arbiter #(
        .TIMEOUT_CYC(TO),
        .GAP_CYC    (GAP),
        .CNT_W      (13)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .i_i2c_busy     (i_i2c_busy),
        .i_run_test_mode(i_run_test_mode),
        .i_prog_lock    (i_prog_lock),
        .i_req          (i_req),
        .i_op           (i_op),
        .o_gnt          (o_gnt),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_otp_start    (o_otp_start),
        .o_otp_prog     (o_otp_prog),
        .i_otp_done     (i_otp_done),
        .o_otp_abort    (o_otp_abort),
        .o_busy         (o_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Output bundle order: {gnt[2:0], done[2:0], err[2:0], start, prog, abort, busy}
    typedef struct {
        logic        rst;
        logic        ibusy;
        logic        rtm;
        logic        lock;
        logic [2:0]  req;
        logic [2:0]  op;
        logic        sdone;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [12:0] outs();
        return {o_gnt, o_done, o_err, o_otp_start, o_otp_prog, o_otp_abort, o_busy};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {gnt,done,err,st,pg,ab,bz}=%b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic b, input logic m, input logic l,
                           input logic [2:0] q, input logic [2:0] p, input logic d,
                           input logic [12:0] x);
        vec_t v;
        v.rst = r; v.ibusy = b; v.rtm = m; v.lock = l;
        v.req = q; v.op = p; v.sdone = d; v.exp = x;
        vecs.push_back(v);
    endtask

    // Bounded wait for a grant (or error) and check who got it
    task automatic wait_gnt(input string name, input logic [2:0] exp);
        int k;
        k = 0;
        while (o_gnt == 3'b000 && o_err == 3'b000 && k < 40) begin
            tick();
            k++;
        end
        check(name, int'(o_gnt), int'(exp));
    endtask

    // Behavioural reference: transaction timestamps instead of a state machine.
    // m_g   = edge at which the current owner was granted (start pulse edge)
    // m_r   = edge at which the last op resolved (done / abort / reject)
    // Arbitration is possible from edge m_r + GAP + 1 on; done is honoured from
    // edge m_g + 2; abort falls on edge m_g + 1 + TO.
    int   m_owner;
    int   m_g;
    int   m_r;
    int   m_ptr;
    logic m_prog;

    task automatic model_reset();
        m_owner = -1;
        m_g     = -1000;
        m_r     = -1000;
        m_ptr   = 1;
        m_prog  = 1'b0;
    endtask

    task automatic model_edge(input int t, input logic ibusy, input logic rtm, input logic lock,
                              input logic sdone, input logic [2:0] req, input logic [2:0] op,
                              output logic [12:0] e);
        logic [2:0] gnt, done, err;
        logic       start, prog, abort, busy;
        int         w;
        gnt = 3'b000; done = 3'b000; err = 3'b000;
        start = 1'b0; prog = 1'b0; abort = 1'b0;
        if (m_owner >= 0) begin
            if (sdone && t >= m_g + 2) begin
                done[m_owner] = 1'b1;
                m_owner = -1;
                m_r = t;
            end else if (t == m_g + 1 + TO) begin
                abort = 1'b1;
                err[m_owner] = 1'b1;
                m_owner = -1;
                m_r = t;
            end else begin
                gnt[m_owner] = 1'b1;
                prog = m_prog;
            end
        end else if (t >= m_r + GAP + 1 && !ibusy) begin
            w = -1;
            if (req[0]) w = 0;
            else if (req[1] && req[2] && rtm) w = m_ptr;
            else if (req[1]) w = 1;
            else if (req[2] && rtm) w = 2;
            if (w >= 0) begin
                if (w != 0 && op[w] && lock) begin
                    err[w] = 1'b1;
                    m_r = t;
                end else begin
                    m_owner = w;
                    m_g = t;
                    m_prog = (w != 0) && op[w];
                    gnt[w] = 1'b1;
                    prog = m_prog;
                    start = 1'b1;
                    if (w != 0) m_ptr = 3 - w;
                end
            end
        end
        busy = (m_owner >= 0) || (t < m_r + GAP);
        e = {gnt, done, err, start, prog, abort, busy};
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  req_r, op_r;
        logic        rtm_r, lock_r, early;
        logic [12:0] e;
        int          done_at, ecnt, t;
        logic [2:0]  rr_exp [3];

        rst = 1'b1; i_i2c_busy = 1'b0; i_run_test_mode = 1'b1; i_prog_lock = 1'b0;
        i_req = 3'b000; i_op = 3'b000; i_otp_done = 1'b0;

        // ---------------- table-driven vectors ----------------
        //       rst busy rtm lock req     op      done  {gnt,done,err,st,pg,ab,bz}
        add_vec(1, 0, 1, 0, 3'b111, 3'b000, 0, 13'b000_000_000_0_0_0_0);
        add_vec(1, 0, 1, 0, 3'b111, 3'b000, 0, 13'b000_000_000_0_0_0_0);
        add_vec(0, 0, 1, 0, 3'b111, 3'b000, 0, 13'b001_000_000_1_0_0_1);
        add_vec(0, 0, 1, 0, 3'b111, 3'b000, 0, 13'b001_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b111, 3'b000, 1, 13'b000_001_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_0);
        // hold-off by i2c busy
        add_vec(0, 1, 1, 0, 3'b001, 3'b000, 0, 13'b000_000_000_0_0_0_0);
        add_vec(0, 1, 1, 0, 3'b001, 3'b000, 0, 13'b000_000_000_0_0_0_0);
        add_vec(0, 0, 1, 0, 3'b001, 3'b000, 0, 13'b001_000_000_1_0_0_1);
        add_vec(0, 0, 1, 0, 3'b001, 3'b000, 0, 13'b001_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b001, 3'b000, 1, 13'b000_001_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_0);
        // program lock reject
        add_vec(0, 0, 1, 1, 3'b010, 3'b010, 0, 13'b000_000_010_0_0_0_1);
        add_vec(0, 0, 1, 1, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 1, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 1, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 1, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_0);
        // autoload op bit ignored even under lock
        add_vec(0, 0, 1, 1, 3'b001, 3'b001, 0, 13'b001_000_000_1_0_0_1);
        add_vec(0, 0, 1, 1, 3'b001, 3'b001, 0, 13'b001_000_000_0_0_0_1);
        add_vec(0, 0, 1, 1, 3'b001, 3'b001, 1, 13'b000_001_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_0);
        // test-mode masking, program op, done during START ignored
        add_vec(0, 0, 0, 0, 3'b100, 3'b100, 0, 13'b000_000_000_0_0_0_0);
        add_vec(0, 0, 1, 0, 3'b100, 3'b100, 0, 13'b100_000_000_1_1_0_1);
        add_vec(0, 0, 1, 0, 3'b100, 3'b100, 1, 13'b100_000_000_0_1_0_1);
        add_vec(0, 0, 1, 0, 3'b100, 3'b100, 0, 13'b100_000_000_0_1_0_1);
        add_vec(0, 0, 1, 0, 3'b100, 3'b100, 1, 13'b000_100_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_1);
        add_vec(0, 0, 1, 0, 3'b000, 3'b000, 0, 13'b000_000_000_0_0_0_0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; i_i2c_busy = vecs[i].ibusy; i_run_test_mode = vecs[i].rtm;
            i_prog_lock = vecs[i].lock; i_req = vecs[i].req; i_op = vecs[i].op;
            i_otp_done = vecs[i].sdone;
            tick();
            check_outs($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        i_otp_done = 1'b0; i_prog_lock = 1'b0; i_run_test_mode = 1'b1; i_i2c_busy = 1'b0;

        // ---------------- read with 20-cycle sequencer latency ----------------
        i_req = 3'b010; i_op = 3'b000;
        tick();
        check("rd_gnt", int'(o_gnt), 2);
        check("rd_start", int'(o_otp_start), 1);
        tick();
        check("rd_start_pulse", int'(o_otp_start), 0);
        repeat (18) tick();
        check("rd_hold", int'(o_gnt), 2);
        i_otp_done = 1'b1;
        tick();
        i_otp_done = 1'b0; i_req = 3'b000;
        check("rd_done", int'(o_done), 2);
        check("rd_gnt_clr", int'(o_gnt), 0);
        repeat (3) tick();
        check("rd_busy_gap", int'(o_busy), 1);
        tick();
        check("rd_busy_low", int'(o_busy), 0);

        // ---------------- round robin between 1 and 2 ----------------
        rst = 1'b1; i_req = 3'b000;
        tick(); tick();
        rst = 1'b0;
        i_req = 3'b110; i_op = 3'b000;
        rr_exp[0] = 3'b010; rr_exp[1] = 3'b100; rr_exp[2] = 3'b010;
        for (int k = 0; k < 3; k++) begin
            wait_gnt($sformatf("rr_gnt%0d", k), rr_exp[k]);
            tick();
            i_otp_done = 1'b1;
            tick();
            i_otp_done = 1'b0;
            check($sformatf("rr_done%0d", k), int'(o_done), int'(rr_exp[k]));
        end
        i_req = 3'b111;
        wait_gnt("rr_autoload", 3'b001);
        tick();
        i_otp_done = 1'b1;
        tick();
        i_otp_done = 1'b0; i_req = 3'b000;
        check("rr_autoload_done", int'(o_done), 1);
        tick();

        // ---------------- timeout ----------------
        i_req = 3'b100; i_op = 3'b000;
        wait_gnt("to_gnt", 3'b100);
        early = 1'b0;
        repeat (TO) begin
            tick();
            if (o_otp_abort || o_gnt != 3'b100) early = 1'b1;
        end
        check("to_no_early_abort", int'(early), 0);
        tick();
        check("to_abort", int'(o_otp_abort), 1);
        check("to_err", int'(o_err), 4);
        check("to_gnt_clr", int'(o_gnt), 0);
        check("to_no_done", int'(o_done), 0);
        i_req = 3'b000;
        tick();
        check("to_abort_pulse", int'(o_otp_abort), 0);

        // ---------------- done on the timeout cycle wins ----------------
        i_req = 3'b010;
        wait_gnt("dt_gnt", 3'b010);
        repeat (TO) tick();
        i_otp_done = 1'b1;
        tick();
        i_otp_done = 1'b0; i_req = 3'b000;
        check("dt_done", int'(o_done), 2);
        check("dt_no_abort", int'(o_otp_abort), 0);
        check("dt_no_err", int'(o_err), 0);
        tick();

        // ---------------- reset mid-op ----------------
        i_req = 3'b001;
        wait_gnt("rm_gnt", 3'b001);
        tick();
        rst = 1'b1; i_req = 3'b000;
        tick();
        check_outs("rm_reset", outs(), 13'd0);
        rst = 1'b0; i_otp_done = 1'b1;
        tick();
        i_otp_done = 1'b0;
        check_outs("rm_after", outs(), 13'd0);

        // ---------------- randomized against the reference model ----------------
        rst = 1'b1; i_req = 3'b000; i_op = 3'b000;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        ecnt = 0; req_r = 3'b000; op_r = 3'b000; done_at = -1;
        rtm_r = 1'b1; lock_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            t = ecnt + 1;
            for (int i = 0; i < 3; i++) begin
                if (o_done[i] || o_err[i]) begin
                    req_r[i] = 1'b0;
                end else if (!req_r[i] && ($urandom % 4 == 0)) begin
                    req_r[i] = 1'b1;
                    op_r[i]  = 1'($urandom % 2);
                end
            end
            if (o_otp_start) done_at = ecnt + int'($urandom_range(1, TO + 3));
            if ($urandom % 16 == 0) rtm_r = ~rtm_r;
            if ($urandom % 8 == 0) lock_r = ~lock_r;
            i_req = req_r; i_op = op_r;
            i_run_test_mode = rtm_r; i_prog_lock = lock_r;
            i_i2c_busy = ($urandom % 4 == 0);
            i_otp_done = (t == done_at) || ($urandom % 40 == 0);
            model_edge(t, i_i2c_busy, i_run_test_mode, i_prog_lock, i_otp_done, i_req, i_op, e);
            tick();
            ecnt = t;
            check_outs("rand", outs(), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
